// File: rtl/tb_pkg.sv
// Shared types and helpers for the Viterbi traceback stage.
// Holds the FSM state enum, legal constraint-length bounds and the state mask helper.
// Pointer sizing comes from the decoder-wide defines in param_def.sv.
`ifndef MAX_CONSTRAINT_LENGTH
`define MAX_CONSTRAINT_LENGTH 8
`endif
`ifndef MAX_STATE_NUM
`define MAX_STATE_NUM 256
`endif

package tb_pkg;

  localparam int ST_W   = `MAX_CONSTRAINT_LENGTH;
  localparam int ST_NUM = `MAX_STATE_NUM;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACE = 2'd1,
    EMIT  = 2'd2,
    DONE  = 2'd3
  } tb_state_t;

  localparam logic [3:0] K_MIN = 4'd3;
  localparam logic [3:0] K_MAX = 4'd9;

  // A code of constraint length k has 2^(k-1) states; the mask keeps the
  // low k-1 bits of a state pointer.
  function automatic logic [ST_W-1:0] st_mask(input logic [3:0] k);
    return ~({ST_W{1'b1}} << (k - 4'd1));
  endfunction

endpackage

// File: rtl/traceback_unit_if.sv
// Handshake and data bundle between the survivor memory, the traceback unit
// and the bit sink. slave = traceback unit side, master = driver side.
// i_best_st is present only when TB_START_BEST_EN is defined.
interface traceback_unit_if;
  import tb_pkg::*;

  logic                         en_tb;
  logic [3:0]                   i_k;
`ifdef TB_START_BEST_EN
  logic [ST_W-1:0]              i_best_st;
`endif
  logic                         i_col_valid;
  logic [ST_NUM-1:0][ST_W-1:0]  i_bck_prv_st;
  logic                         o_col_rdy;
  logic                         o_bit;
  logic                         o_bit_valid;
  logic                         i_bit_rdy;
  logic                         o_busy;
  logic                         o_done;

  modport slave (
    input  en_tb,
    input  i_k,
`ifdef TB_START_BEST_EN
    input  i_best_st,
`endif
    input  i_col_valid,
    input  i_bck_prv_st,
    output o_col_rdy,
    output o_bit,
    output o_bit_valid,
    input  i_bit_rdy,
    output o_busy,
    output o_done
  );

  modport master (
    output en_tb,
    output i_k,
`ifdef TB_START_BEST_EN
    output i_best_st,
`endif
    output i_col_valid,
    output i_bck_prv_st,
    input  o_col_rdy,
    input  o_bit,
    input  o_bit_valid,
    output i_bit_rdy,
    input  o_busy,
    input  o_done
  );

endinterface

// File: rtl/param_def.sv
// Global decoder sizing shared by the trellis, survivor memory and traceback.
// MAX_CONSTRAINT_LENGTH: state pointer width; MAX_STATE_NUM: states per column.
// Definitions are guarded so the file may be seen more than once.
`ifndef MAX_CONSTRAINT_LENGTH
`define MAX_CONSTRAINT_LENGTH 8
`endif
`ifndef MAX_STATE_NUM
`define MAX_STATE_NUM 256
`endif

// File: rtl/tb_lifo.sv
// DEPTH x 1-bit stack that reverses traceback order into output order.
// Ports: push/din write at the pointer, pop drops the top, top = last pushed bit,
// last = exactly one entry held. Pointer is synchronous with async active-high reset.
module tb_lifo #(
  parameter int DEPTH = 45
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic top,
  output logic last
);

  localparam int PW    = $clog2(DEPTH + 1);
  // Storage is rounded up to the pointer range so the pointer indexes it directly.
  localparam int SLOTS = 1 << PW;

  logic [PW-1:0]    ptr_q, ptr_d;
  logic [SLOTS-1:0] mem_q, mem_d;
  logic [PW-1:0]    top_idx;

  always_comb begin
    mem_d   = mem_q;
    ptr_d   = ptr_q;
    top_idx = ptr_q - PW'(1);
    if (push) begin
      mem_d[ptr_q] = din;
      ptr_d        = ptr_q + PW'(1);
    end else if (pop) begin
      ptr_d = ptr_q - PW'(1);
    end
  end

  assign top  = (ptr_q != '0) ? mem_q[top_idx] : 1'b0;
  assign last = (ptr_q == PW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      mem_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/traceback_unit.sv
// Viterbi survivor-path traceback: walks TB_DEPTH predecessor columns newest
// first from a start state, then emits the decoded bits oldest first.
// Ports: clk, rst (async active-high), tb_if (slave side of traceback_unit_if).
// Build option TB_START_BEST_EN: start from i_best_st instead of state 0.
module traceback_unit
  import tb_pkg::*;
#(
  parameter int TB_DEPTH = 45
) (
  input  logic             clk,
  input  logic             rst,
  traceback_unit_if.slave  tb_if
);

  localparam int CW = $clog2(TB_DEPTH + 1);

  tb_state_t       state_q, state_d;
  logic [3:0]      k_q, k_d;
  logic [ST_W-1:0] cur_st_q, cur_st_d;
  logic [CW-1:0]   col_cnt_q, col_cnt_d;

  logic [ST_W-1:0] start_st;
  logic [ST_W-1:0] next_st;
  logic [ST_W-1:0] dec_sel;
  logic            col_acc;
  logic            bit_acc;
  logic            k_ok;
  logic            push_bit;
  logic            lifo_top;
  logic            lifo_last;

`ifdef TB_START_BEST_EN
  assign start_st = tb_if.i_best_st;
`else
  assign start_st = '0;
`endif

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    cur_st_d  = cur_st_q;
    col_cnt_d = col_cnt_q;

    col_acc = (state_q == TRACE) && tb_if.i_col_valid;
    bit_acc = (state_q == EMIT) && tb_if.i_bit_rdy;
    k_ok    = (tb_if.i_k >= K_MIN) && (tb_if.i_k <= K_MAX);

    // Masking the looked-up pointer keeps cur_st inside the active state
    // space, so entries above the mask are never addressed.
    next_st  = tb_if.i_bck_prv_st[cur_st_q] & st_mask(k_q);
    // The decoded bit is the MSB of the (k-1)-bit state.
    dec_sel  = ST_W'(1) << (k_q - 4'd2);
    push_bit = |(cur_st_q & dec_sel);

    case (state_q)
      IDLE: begin
        if (tb_if.en_tb && k_ok) begin
          state_d   = TRACE;
          k_d       = tb_if.i_k;
          cur_st_d  = start_st & st_mask(tb_if.i_k);
          col_cnt_d = '0;
        end
      end
      TRACE: begin
        if (col_acc) begin
          cur_st_d  = next_st;
          col_cnt_d = col_cnt_q + CW'(1);
          if (col_cnt_d == CW'(TB_DEPTH)) begin
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        if (bit_acc && lifo_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  tb_lifo #(
    .DEPTH (TB_DEPTH)
  ) u_lifo (
    .clk  (clk),
    .rst  (rst),
    .push (col_acc),
    .din  (push_bit),
    .pop  (bit_acc),
    .top  (lifo_top),
    .last (lifo_last)
  );

  assign tb_if.o_col_rdy   = (state_q == TRACE);
  assign tb_if.o_bit_valid = (state_q == EMIT);
  assign tb_if.o_bit       = (state_q == EMIT) && lifo_top;
  assign tb_if.o_busy      = (state_q != IDLE);
  assign tb_if.o_done      = (state_q == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      cur_st_q  <= '0;
      col_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      cur_st_q  <= cur_st_d;
      col_cnt_q <= col_cnt_d;
    end
  end

endmodule

// File: tb/tb_traceback_unit.sv
// Directed bench for traceback_unit with TB_DEPTH=4.
// Table of {k, columns, expected bits} plus hand sequences for backpressure,
// illegal k, en_tb while busy and reset in the middle of EMIT.
module tb_traceback_unit;

  localparam int DEPTH = 4;
  localparam int SW    = tb_pkg::ST_W;
  localparam int SN    = tb_pkg::ST_NUM;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  traceback_unit_if tbi();

  traceback_unit #(
    .TB_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .tb_if (tbi.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            nm;
    logic [3:0]       k;
`ifdef TB_START_BEST_EN
    logic [SW-1:0]    best;
`endif
    logic [3:0][7:0]  cols;   // cols[0] is the first (newest) column fed
    bit               dirty;  // fill entries above the mask with garbage
    logic [3:0]       exp;    // exp[0] is the first bit emitted
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [SN-1:0][SW-1:0] mkcol(input logic [7:0] v, input logic [3:0] k, input bit dirty);
    logic [SN-1:0][SW-1:0] c;
    int m;
    m = (1 << (int'(k) - 1)) - 1;
    for (int i = 0; i < SN; i++) begin
      c[i] = (dirty && i > m) ? SW'(~v) : SW'(v);
    end
    return c;
  endfunction

  // Feeds four columns; returns the number of cycles spent.
  task automatic feed(input string nm, input logic [3:0] k, input logic [3:0][7:0] cols,
                      input bit dirty, input bit gapped, input bit poke, output int cycles);
    bit gap_pat[6] = '{1, 0, 1, 1, 0, 1};
    int c = 0;
    int g = 0;
    bit v;
    bit acc;
    tbi.i_bit_rdy = 1'b1;  // must be ignored outside EMIT
    while (c < 4 && g < 50) begin
      v = gapped ? gap_pat[g % 6] : 1'b1;
      tbi.i_col_valid  = v;
      tbi.i_bck_prv_st = mkcol(cols[c], k, dirty);
      if (poke && g == 1) begin
        tbi.en_tb = 1'b1;
        tbi.i_k   = 4'd4;
      end else begin
        tbi.en_tb = 1'b0;
      end
      acc = v && tbi.o_col_rdy;
      @(posedge clk); #1;
      if (acc) c++;
      g++;
    end
    tbi.en_tb       = 1'b0;
    tbi.i_col_valid = 1'b0;
    tbi.i_bit_rdy   = 1'b0;
    chk({nm, "_feed_done"}, 32'(c), 32'd4);
    cycles = g;
  endtask

  // Collects nbits; with stall, i_bit_rdy is held low 3 cycles after 2 bits.
  task automatic collect(input string nm, input int nbits, input bit stall,
                         output logic [3:0] bits, output int cycles);
    int   got  = 0;
    int   g    = 0;
    int   hold = 0;
    logic held = 1'b0;
    bit   rdy;
    bits = '0;
    chk({nm, "_bit_valid_rise"}, 32'(tbi.o_bit_valid), 32'd1);
    while (got < nbits && g < 50) begin
      rdy = !(stall && got == 2 && hold < 3);
      tbi.i_bit_rdy = rdy;
      if (!rdy) begin
        chk({nm, "_stall_valid"}, 32'(tbi.o_bit_valid), 32'd1);
        if (hold == 0) held = tbi.o_bit;
        else chk({nm, "_stall_stable"}, 32'(tbi.o_bit), 32'(held));
        hold++;
      end else if (tbi.o_bit_valid) begin
        if (stall && got == 2) chk({nm, "_post_stall_bit"}, 32'(tbi.o_bit), 32'(held));
        bits[got] = tbi.o_bit;
        got++;
      end
      @(posedge clk); #1;
      g++;
    end
    tbi.i_bit_rdy = 1'b0;
    chk({nm, "_collect_done"}, 32'(got), 32'(nbits));
    cycles = g;
  endtask

  task automatic run_vec(input vec_t v, input bit gapped, input bit stall, input bit poke);
    logic [3:0] bits;
    int fc;
    int cc;
    chk({v.nm, "_idle_rdy"}, 32'(tbi.o_col_rdy), 32'd0);
    tbi.en_tb = 1'b1;
    tbi.i_k   = v.k;
`ifdef TB_START_BEST_EN
    tbi.i_best_st = v.best;
`endif
    @(posedge clk); #1;
    tbi.en_tb = 1'b0;
    chk({v.nm, "_busy_c1"}, 32'(tbi.o_busy), 32'd1);
    chk({v.nm, "_col_rdy_c1"}, 32'(tbi.o_col_rdy), 32'd1);
    chk({v.nm, "_bit_valid_c1"}, 32'(tbi.o_bit_valid), 32'd0);
    feed(v.nm, v.k, v.cols, v.dirty, gapped, poke, fc);
    if (!gapped) chk({v.nm, "_feed_cycles"}, 32'(fc), 32'd4);
    collect(v.nm, 4, stall, bits, cc);
    if (!stall) chk({v.nm, "_collect_cycles"}, 32'(cc), 32'd4);
    chk({v.nm, "_bits"}, 32'(bits), 32'(v.exp));
    chk({v.nm, "_done_pulse"}, 32'(tbi.o_done), 32'd1);
    chk({v.nm, "_busy_in_done"}, 32'(tbi.o_busy), 32'd1);
    @(posedge clk); #1;
    chk({v.nm, "_done_clear"}, 32'(tbi.o_done), 32'd0);
    chk({v.nm, "_busy_clear"}, 32'(tbi.o_busy), 32'd0);
  endtask

  function automatic vec_t mkvec(input string nm, input logic [3:0] k, input logic [SW-1:0] best,
                                 input logic [3:0][7:0] cols, input bit dirty, input logic [3:0] exp);
    vec_t v;
    v.nm = nm; v.k = k; v.cols = cols; v.dirty = dirty; v.exp = exp;
`ifdef TB_START_BEST_EN
    v.best = best;
`else
    if (best != '0) $display("note: start state ignored in this build");
`endif
    return v;
  endfunction

  initial begin : main
    logic [3:0] bits;
    int         cc;
    int         fc;

    tbi.en_tb        = 1'b0;
    tbi.i_k          = 4'd0;
`ifdef TB_START_BEST_EN
    tbi.i_best_st    = '0;
`endif
    tbi.i_col_valid  = 1'b0;
    tbi.i_bck_prv_st = '0;
    tbi.i_bit_rdy    = 1'b0;

    // Expected bits derived by hand: push MSB of the (k-1)-bit state, then
    // follow the pointer; output is the push order reversed.
    vt.push_back(mkvec("zero",   4'd3, '0, {8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 4'b0000));
    vt.push_back(mkvec("alt12",  4'd3, '0, {8'h02, 8'h01, 8'h02, 8'h01}, 1'b0, 4'b0010));
    vt.push_back(mkvec("all3",   4'd3, '0, {8'h03, 8'h03, 8'h03, 8'h03}, 1'b1, 4'b0111));
    vt.push_back(mkvec("k4",     4'd4, '0, {8'h04, 8'h02, 8'h01, 8'h04}, 1'b1, 4'b0100));
    vt.push_back(mkvec("k9",     4'd9, '0, {8'h7F, 8'hFF, 8'h01, 8'h80}, 1'b0, 4'b0101));
    vt.push_back(mkvec("k5mask", 4'd5, '0, {8'hF8, 8'hF8, 8'hF8, 8'hF8}, 1'b1, 4'b0111));
`ifdef TB_START_BEST_EN
    vt.push_back(mkvec("best3",  4'd3, SW'(3), {8'h02, 8'h02, 8'h02, 8'h02}, 1'b0, 4'b1111));
`endif

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst_col_rdy",   32'(tbi.o_col_rdy),   32'd0);
    chk("rst_bit",       32'(tbi.o_bit),       32'd0);
    chk("rst_bit_valid", 32'(tbi.o_bit_valid), 32'd0);
    chk("rst_busy",      32'(tbi.o_busy),      32'd0);
    chk("rst_done",      32'(tbi.o_done),      32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < vt.size(); i++) begin
      run_vec(vt[i], 1'b0, 1'b0, 1'b0);
    end

    // Backpressure: gapped columns and a 3-cycle output stall
    run_vec(mkvec("bp", 4'd3, '0, {8'h02, 8'h01, 8'h02, 8'h01}, 1'b0, 4'b0010), 1'b1, 1'b1, 1'b0);

    // Illegal constraint lengths are ignored
    for (int i = 0; i < 2; i++) begin
      tbi.en_tb = 1'b1;
      tbi.i_k   = (i == 0) ? 4'd2 : 4'd10;
      @(posedge clk); #1;
      tbi.en_tb = 1'b0;
      chk($sformatf("illegal_k%0d_busy", tbi.i_k), 32'(tbi.o_busy), 32'd0);
      chk($sformatf("illegal_k%0d_col_rdy", tbi.i_k), 32'(tbi.o_col_rdy), 32'd0);
      @(posedge clk); #1;
    end

    // en_tb with a different k during TRACE must not disturb the run
    run_vec(mkvec("poke", 4'd3, '0, {8'h02, 8'h01, 8'h02, 8'h01}, 1'b0, 4'b0010), 1'b0, 1'b0, 1'b1);

    // Reset after 2 of 4 bits, then a fresh run
    tbi.en_tb = 1'b1;
    tbi.i_k   = 4'd3;
`ifdef TB_START_BEST_EN
    tbi.i_best_st = '0;
`endif
    @(posedge clk); #1;
    tbi.en_tb = 1'b0;
    feed("mid", 4'd3, {8'h02, 8'h01, 8'h02, 8'h01}, 1'b0, 1'b0, 1'b0, fc);
    collect("mid", 2, 1'b0, bits, cc);
    chk("mid_first_bits", 32'(bits[1:0]), 32'd2);
    chk("mid_valid_before_rst", 32'(tbi.o_bit_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_col_rdy",   32'(tbi.o_col_rdy),   32'd0);
    chk("mid_rst_bit",       32'(tbi.o_bit),       32'd0);
    chk("mid_rst_bit_valid", 32'(tbi.o_bit_valid), 32'd0);
    chk("mid_rst_busy",      32'(tbi.o_busy),      32'd0);
    chk("mid_rst_done",      32'(tbi.o_done),      32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_vec(mkvec("after_rst", 4'd9, '0, {8'h7F, 8'hFF, 8'h01, 8'h80}, 1'b0, 4'b0101), 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
